// File: rtl/alu_result_stage.sv
// alu_result_stage: registered 2-entry elastic stage between the i16 ALU
// (including the multiplication unit) and writeback.
// Each entry holds {result, overflow, rd}. in_ready comes only from registered
// state, so there is no combinational path from out_ready to in_ready.
// Writes to register 0 are stored as zero result with no overflow.
// The stage also keeps a sticky overflow flag for the core.
// Optional feature (macro ALU_RESULT_OVF_COUNT_EN): adds a saturating 8-bit
// counter of overflow pushes on the ovf_count output.
module alu_result_stage #(
   parameter int l  = 16,
   parameter int RW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [l-1:0]  in_result,
   input  logic          in_overflow,
   input  logic [RW-1:0] in_rd,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [l-1:0]  out_result,
   output logic          out_overflow,
   output logic [RW-1:0] out_rd,
   output logic          ovf_sticky,
   input  logic          ovf_clear
`ifdef ALU_RESULT_OVF_COUNT_EN
   ,
   output logic [7:0]    ovf_count
`endif
);

   logic [l-1:0]  result_mem [2];
   logic          ovf_mem    [2];
   logic [RW-1:0] rd_mem     [2];
   logic [1:0]    count_reg;
   logic          wr_ptr_reg;
   logic          rd_ptr_reg;
   logic          sticky_reg;

   logic          push;
   logic          pop;
   logic          wr_zero;
   logic [l-1:0]  wr_result;
   logic          wr_ovf;

   // Handshake status and head presentation, all from registered state.
   assign in_ready     = (count_reg != 2'd2);
   assign out_valid    = (count_reg != 2'd0);
   assign push         = in_valid && in_ready;
   assign pop          = out_valid && out_ready;
   assign out_result   = out_valid ? result_mem[rd_ptr_reg] : '0;
   assign out_overflow = out_valid ? ovf_mem[rd_ptr_reg]    : 1'b0;
   assign out_rd       = out_valid ? rd_mem[rd_ptr_reg]     : '0;
   assign ovf_sticky   = sticky_reg;

   // Register 0 is hardwired to zero, so its writes never carry data or overflow.
   assign wr_zero   = (in_rd == '0);
   assign wr_result = wr_zero ? '0 : in_result;
   assign wr_ovf    = wr_zero ? 1'b0 : in_overflow;

   // Entry storage: write the tail slot on push; everything is cleared by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            result_mem[i] <= '0;
            ovf_mem[i]    <= 1'b0;
            rd_mem[i]     <= '0;
         end
      end else if (push) begin
         result_mem[wr_ptr_reg] <= wr_result;
         ovf_mem[wr_ptr_reg]    <= wr_ovf;
         rd_mem[wr_ptr_reg]     <= in_rd;
      end
   end

   // Occupancy and the 1-bit wrapping pointers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_reg  <= 2'd0;
         wr_ptr_reg <= 1'b0;
         rd_ptr_reg <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_reg <= ~wr_ptr_reg;
         end
         if (pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
         if (push && !pop) begin
            count_reg <= count_reg + 2'd1;
         end else if (pop && !push) begin
            count_reg <= count_reg - 2'd1;
         end
      end
   end

   // Sticky overflow: a pushed overflow wins over a same-cycle clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sticky_reg <= 1'b0;
      end else if (push && wr_ovf) begin
         sticky_reg <= 1'b1;
      end else if (ovf_clear) begin
         sticky_reg <= 1'b0;
      end
   end

`ifdef ALU_RESULT_OVF_COUNT_EN
   logic [7:0] ovf_count_reg;

   assign ovf_count = ovf_count_reg;

   // Saturating overflow counter; a same-cycle clear and increment leaves 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_count_reg <= 8'd0;
      end else if (push && wr_ovf) begin
         if (ovf_clear) begin
            ovf_count_reg <= 8'd1;
         end else if (ovf_count_reg != 8'hFF) begin
            ovf_count_reg <= ovf_count_reg + 8'd1;
         end
      end else if (ovf_clear) begin
         ovf_count_reg <= 8'd0;
      end
   end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed bench for alu_result_stage.
// A queue-based model follows the handshake rules; a negedge process compares
// every output against it, and directed steps add literal expectations.
module tb_alu_result_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_result;
   logic        in_overflow;
   logic [2:0]  in_rd;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic        out_overflow;
   logic [2:0]  out_rd;
   logic        ovf_sticky;
   logic        ovf_clear;
`ifdef ALU_RESULT_OVF_COUNT_EN
   logic [7:0]  ovf_count;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_result_stage #(.l(16), .RW(3)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_result(in_result),
      .in_overflow(in_overflow),
      .in_rd(in_rd),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_result(out_result),
      .out_overflow(out_overflow),
      .out_rd(out_rd),
      .ovf_sticky(ovf_sticky),
      .ovf_clear(ovf_clear)
`ifdef ALU_RESULT_OVF_COUNT_EN
      ,
      .ovf_count(ovf_count)
`endif
   );

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [15:0] r;
      logic        o;
      logic [2:0]  d;
   } ent_t;

   ent_t q[$];
   bit   m_sticky = 1'b0;
   int   m_cnt    = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         m_sticky = 1'b0;
         m_cnt    = 0;
      end else begin
         bit   do_push;
         bit   do_pop;
         ent_t e;
         do_push = in_valid && (q.size() < 2);
         do_pop  = out_ready && (q.size() > 0);
         e.d = in_rd;
         e.r = (in_rd == 3'd0) ? 16'd0 : in_result;
         e.o = (in_rd == 3'd0) ? 1'b0 : in_overflow;
         if (do_pop) void'(q.pop_front());
         if (do_push) q.push_back(e);
         if (do_push && e.o) m_sticky = 1'b1;
         else if (ovf_clear) m_sticky = 1'b0;
         if (do_push && e.o) m_cnt = ovf_clear ? 1 : ((m_cnt >= 255) ? 255 : m_cnt + 1);
         else if (ovf_clear) m_cnt = 0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      ent_t h;
      h = '{r: 16'd0, o: 1'b0, d: 3'd0};
      if (q.size() > 0) h = q[0];
      chk("m_out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
      chk("m_in_ready", {31'd0, in_ready}, {31'd0, q.size() != 2});
      chk("m_out_result", {16'd0, out_result}, {16'd0, h.r});
      chk("m_out_overflow", {31'd0, out_overflow}, {31'd0, h.o});
      chk("m_out_rd", {29'd0, out_rd}, {29'd0, h.d});
      chk("m_sticky", {31'd0, ovf_sticky}, {31'd0, m_sticky});
`ifdef ALU_RESULT_OVF_COUNT_EN
      chk("m_ovf_count", {24'd0, ovf_count}, m_cnt);
`endif
   end

   // Drive one cycle of inputs, then step to 1 time unit after the edge.
   task automatic cyc(input logic v, input logic [15:0] r, input logic o,
                      input logic [2:0] d, input logic ordy, input logic clr);
      in_valid    = v;
      in_result   = r;
      in_overflow = o;
      in_rd       = d;
      out_ready   = ordy;
      ovf_clear   = clr;
      @(posedge clk);
      #1;
      $display("cyc v=%0d r=%04h o=%0d rd=%0d ordy=%0d clr=%0d -> ov=%0d or=%04h oo=%0d ord=%0d ir=%0d st=%0d",
               v, r, o, d, ordy, clr, out_valid, out_result, out_overflow, out_rd, in_ready, ovf_sticky);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 0; in_result = 0; in_overflow = 0; in_rd = 0;
      out_ready = 0; ovf_clear = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;

      // single push 0x7FFF rd3
      cyc(1, 16'h7FFF, 0, 3'd3, 1, 0);
      chk("t1_valid", {31'd0, out_valid}, 32'd1);
      chk("t1_result", {16'd0, out_result}, 32'h7FFF);
      chk("t1_rd", {29'd0, out_rd}, 32'd3);
      chk("t1_ovf", {31'd0, out_overflow}, 32'd0);
      chk("t1_sticky", {31'd0, ovf_sticky}, 32'd0);
      cyc(0, 0, 0, 0, 1, 0);
      chk("t1_drain", {31'd0, out_valid}, 32'd0);

      // overflow push sets sticky, clear drops it
      cyc(1, 16'h0000, 1, 3'd2, 0, 0);
      chk("t2_ovf", {31'd0, out_overflow}, 32'd1);
      chk("t2_sticky", {31'd0, ovf_sticky}, 32'd1);
      cyc(0, 0, 0, 0, 1, 1);
      chk("t2_clear", {31'd0, ovf_sticky}, 32'd0);

      // fill to 2, third push refused, ordered drain
      cyc(1, 16'h0001, 0, 3'd1, 0, 0);
      cyc(1, 16'h0003, 0, 3'd2, 0, 0);
      chk("t3_full_ready", {31'd0, in_ready}, 32'd0);
      cyc(1, 16'h0005, 0, 3'd3, 0, 0);
      chk("t3_head", {16'd0, out_result}, 32'h0001);
      cyc(0, 0, 0, 0, 1, 0);
      chk("t3_pop2", {16'd0, out_result}, 32'h0003);
      chk("t3_ready_back", {31'd0, in_ready}, 32'd1);
      cyc(0, 0, 0, 0, 1, 0);
      chk("t3_empty", {31'd0, out_valid}, 32'd0);

      // streaming at count 1: values 1..10
      for (int i = 1; i <= 10; i++) begin
         cyc(1, 16'(i), 0, 3'd4, 1, 0);
         chk("t4_stream", {16'd0, out_result}, i);
         chk("t4_ready", {31'd0, in_ready}, 32'd1);
      end
      cyc(0, 0, 0, 0, 1, 0);

      // rd0 rule, and set-wins-over-clear
      cyc(1, 16'hFFFF, 1, 3'd0, 1, 0);
      chk("t5_result", {16'd0, out_result}, 32'd0);
      chk("t5_ovf", {31'd0, out_overflow}, 32'd0);
      chk("t5_sticky", {31'd0, ovf_sticky}, 32'd0);
      cyc(1, 16'h1234, 1, 3'd5, 1, 1);
      chk("t5_set_wins", {31'd0, ovf_sticky}, 32'd1);
      cyc(0, 0, 0, 0, 1, 1);
      chk("t5_cleared", {31'd0, ovf_sticky}, 32'd0);

      // async reset with two entries held
      cyc(1, 16'h00AA, 1, 3'd6, 0, 0);
      cyc(1, 16'h00BB, 0, 3'd7, 0, 0);
      in_valid = 0;
      #2;
      rst = 1'b1;
      #1;
      chk("t6_valid", {31'd0, out_valid}, 32'd0);
      chk("t6_ready", {31'd0, in_ready}, 32'd1);
      chk("t6_result", {16'd0, out_result}, 32'd0);
      chk("t6_sticky", {31'd0, ovf_sticky}, 32'd0);
      @(posedge clk);
      #3;
      rst = 1'b0;
      @(posedge clk);
      #1;

`ifdef ALU_RESULT_OVF_COUNT_EN
      cyc(1, 16'h0001, 1, 3'd1, 1, 0);
      chk("t7_one", {24'd0, ovf_count}, 32'd1);
      for (int i = 0; i < 299; i++) cyc(1, 16'h0001, 1, 3'd1, 1, 0);
      chk("t7_sat", {24'd0, ovf_count}, 32'd255);
      cyc(1, 16'h0002, 1, 3'd1, 1, 1);
      chk("t7_clr_inc", {24'd0, ovf_count}, 32'd1);
      cyc(0, 0, 0, 0, 1, 1);
      chk("t7_clr", {24'd0, ovf_count}, 32'd0);
`endif

      cyc(0, 0, 0, 0, 1, 0);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered, 2-entry elastic stage directly downstream of the combinational multiplication unit (and the other ALU ops) in the i16 datapath.
- Captures the ALU result word, overflow flag and destination register index, and hands them to writeback over a valid/ready handshake.
- Absorbs one cycle of writeback backpressure without a combinational ready path.
- Keeps a sticky overflow status flag for the core.

Parameters:
l, 16, datapath width; matches the multiplication unit width
RW, 3, destination register index width (8 architectural registers)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  ALU result present this cycle
in_ready  output  1  stage can accept; a push occurs when in_valid && in_ready
in_result  input  l  ALU result word (S from multiplication)
in_overflow  input  1  ALU overflow (Overflow from multiplication)
in_rd  input  RW  destination register index
out_valid  output  1  head entry valid
out_ready  input  1  writeback accepts; a pop occurs when out_valid && out_ready
out_result  output  l  head result
out_overflow  output  1  head overflow
out_rd  output  RW  head destination
ovf_sticky  output  1  set by any pushed overflow; held until cleared
ovf_clear  input  1  synchronous clear of ovf_sticky

Behaviour:
- Storage: 2 entries, each holding {result, overflow, rd}. Occupancy count is 0..2. Read and write pointers are 1 bit and toggle (wrap) on every pop and push respectively.
- in_ready = (count != 2). It is derived only from registered state, with no path from out_ready.
- out_valid = (count != 0).
  - out_* show the head entry.
  - When count==0, out_result, out_overflow and out_rd are driven to 0.
- Latency: a push at edge N appears on out_* after edge N. Minimum in-to-out latency is 1 cycle. No bypass.
- Register-0 rule: if in_rd==0, the stored result is forced to 0 and the stored overflow to 0; in_rd is stored as 0.
- Count transitions per edge:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged. The head advances and the new entry goes to the tail.
  - count==2: no push is possible. A pop gives count 1 and in_ready rises the next cycle.
  - count==0: no pop is possible. out_ready is ignored.
- Sticky flag:
  - Set at the edge of any push whose stored overflow is 1.
  - ovf_clear clears it at the next edge.
  - Set and clear in the same cycle: set wins.
- Reset (async, any time, including mid-transfer):
  - count=0, pointers=0, entries=0, ovf_sticky=0.
  - Therefore out_valid=0, out_*=0, in_ready=1 immediately.
  - Entries in flight are discarded.
- Data stability: while out_valid && !out_ready, out_* hold constant.

Optional Feature:
- Macro: ALU_RESULT_OVF_COUNT_EN.
- Defined: adds output ovf_count [7:0].
  - Increments on each push with stored overflow 1 and saturates at 255.
  - ovf_clear resets it to 0; same-cycle increment and clear gives 1.
  - Reset value is 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then single push of result 0x7FFF, overflow 0, rd 3 with out_ready=1 -> next cycle out_valid=1, out_result=0x7FFF, out_rd=3, out_overflow=0; ovf_sticky stays 0.
- Push of result 0x0000, overflow 1, rd 2 (the 0x8000*0x0400 case) -> out_overflow=1, ovf_sticky=1 after the edge; assert ovf_clear for 1 cycle -> ovf_sticky=0.
- out_ready=0, push 0x0001 (rd1) then 0x0003 (rd2) -> count=2, in_ready=0, and a third push is refused. Raise out_ready -> pops return 0x0001 then 0x0003 in order.
- count=1 with simultaneous push and pop every cycle for 10 cycles, values 1..10 -> in_ready stays 1 and the output sequence is 1..10 with no gaps after the first.
- Push result 0xFFFF, overflow 1, rd 0 -> out_result=0, out_overflow=0, ovf_sticky unchanged.
- Assert rst mid-cycle with 2 entries held -> out_valid=0 and in_ready=1 before the next clk edge. With ALU_RESULT_OVF_COUNT_EN, 300 overflow pushes -> ovf_count=255.
